// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - fetch, input-port and ALU signal bundle for the sequencer
interface cpu_sequencer_if #(
   parameter int PC_W = 8
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [15:0]     imem_rdata;

   logic [15:0]     in_data;
   logic            in_valid;
   logic            in_ready;

   logic [15:0]     alu_instr;
   logic [15:0]     alu_inreg1;
   logic [15:0]     alu_inreg2;
   logic [15:0]     alu_inp;
   logic            alu_carryin;
   logic [15:0]     alu_out;
   logic            alu_carryout;

   // sequencer side
   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      input  in_data, in_valid,
      output in_ready,
      output alu_instr, alu_inreg1, alu_inreg2, alu_inp, alu_carryin,
      input  alu_out, alu_carryout
   );

   // memory / input port / ALU side
   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      output in_data, in_valid,
      input  in_ready,
      input  alu_instr, alu_inreg1, alu_inreg2, alu_inp, alu_carryin,
      output alu_out, alu_carryout
   );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/execute controller for the 16-bit CPU
module cpu_sequencer #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   cpu_sequencer_if.master bus,
   output logic [PC_W-1:0] pc,
   output logic            carry_flag,
   output logic            halted,
   output logic            illegal
);
   typedef enum logic [1:0] {S_FETCH, S_WAIT_IN, S_EXEC, S_HALT} state_t;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_JMP  = 8'h80;
   localparam logic [7:0] OP_JC   = 8'h81;
   localparam logic [7:0] OP_IN   = 8'hFC;
   localparam logic [7:0] OP_HALT = 8'hFF;

   state_t      state;
   logic [15:0] ir;
   logic [15:0] inp;
   logic [15:0] regs [4];
   logic        carry;

   logic [7:0]  op;
   logic [1:0]  rd;
   logic [1:0]  rm;
   logic [1:0]  rn;
   logic        cen;
   logic        op_alu;
   logic        op_known;

   assign op  = ir[15:8];
   assign rd  = ir[7:6];
   assign rm  = ir[5:4];
   assign rn  = ir[3:2];
   assign cen = ir[1];

   // opcode classification: F8..FD write the ALU result back
   always_comb begin
      op_alu   = (op >= 8'hF8) && (op <= 8'hFD);
      op_known = op_alu || (op == OP_NOP) || (op == OP_JMP) ||
                 (op == OP_JC) || (op == OP_HALT);
   end

   // handshakes are decoded from state and forced low while reset is held
   assign bus.imem_req  = (state == S_FETCH) && !rst;
   assign bus.imem_addr = pc;
   assign bus.in_ready  = (state == S_WAIT_IN) && !rst;

   assign bus.alu_instr   = ir;
   assign bus.alu_inreg1  = regs[rm];
   assign bus.alu_inreg2  = regs[rn];
   assign bus.alu_inp     = inp;
   assign bus.alu_carryin = carry;

   assign carry_flag = carry;
   assign halted     = (state == S_HALT);
   assign illegal    = (state == S_EXEC) && !op_known && !rst;

   // fetch / input wait / execute / halt sequencing with register-file writeback
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
         pc    <= RESET_PC;
         ir    <= '0;
         inp   <= '0;
         carry <= 1'b0;
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (bus.imem_ack) begin
                  ir    <= bus.imem_rdata;
                  pc    <= pc + PC_W'(1);
                  state <= (bus.imem_rdata[15:8] == OP_IN) ? S_WAIT_IN : S_EXEC;
               end
            end
            S_WAIT_IN: begin
               if (bus.in_valid) begin
                  inp   <= bus.in_data;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               state <= S_FETCH;
               if (op_alu) begin
                  regs[rd] <= bus.alu_out;
                  if (cen) carry <= bus.alu_carryout;
               end else if (op == OP_JMP) begin
                  pc <= ir[PC_W-1:0];
               end else if (op == OP_JC) begin
                  if (carry) pc <= ir[PC_W-1:0];
               end else if (op == OP_HALT) begin
                  state <= S_HALT;
               end
            end
            default: begin
               state <= S_HALT;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] pc;
   logic       carry_flag;
   logic       halted;
   logic       illegal;

   cpu_sequencer_if #(.PC_W(8)) bus ();

   cpu_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .pc         (pc),
      .carry_flag (carry_flag),
      .halted     (halted),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // instruction-level model state
   logic [7:0]  m_pc;
   logic [15:0] m_ir;
   logic [15:0] m_inp;
   logic [15:0] m_r [4];
   logic        m_c;

   // reference ALU: 17-bit result, bit 16 is carry
   function automatic logic [16:0] alu_fn(input logic [15:0] instr, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] p,
                                          input logic c);
      logic [16:0] ci;
      logic [31:0] prod;
      ci   = {16'h0, instr[0] & c};
      prod = a * b;
      case (instr[15:8])
         8'hF8:   return {1'b0, a} + {1'b0, b} + ci;
         8'hF9:   return {1'b0, a} - {1'b0, b} - ci;
         8'hFA:   return {1'b0, a} + 17'd1;
         8'hFB:   return {1'b0, a} - 17'd1;
         8'hFC:   return {1'b0, p};
         8'hFD:   return prod[16:0];
         default: return 17'h0;
      endcase
   endfunction

   // the environment ALU, fed from the DUT's ALU outputs
   always_comb begin
      {bus.alu_carryout, bus.alu_out} = alu_fn(bus.alu_instr, bus.alu_inreg1, bus.alu_inreg2,
                                               bus.alu_inp, bus.alu_carryin);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc  = 8'h00;
      m_ir  = 16'h0;
      m_inp = 16'h0;
      m_c   = 1'b0;
      for (int i = 0; i < 4; i++) m_r[i] = 16'h0;
   endtask

   task automatic chk_fetch();
      chk("fetch_req",   32'(bus.imem_req), 32'd1);
      chk("fetch_addr",  32'(bus.imem_addr), 32'(m_pc));
      chk("fetch_pc",    32'(pc), 32'(m_pc));
      chk("fetch_ready", 32'(bus.in_ready), 32'd0);
      chk("fetch_illegal", 32'(illegal), 32'd0);
      chk("fetch_halted",  32'(halted), 32'd0);
      chk("fetch_ir",    32'(bus.alu_instr), 32'(m_ir));
      chk("fetch_carry", 32'(carry_flag), 32'(m_c));
   endtask

   // one instruction: fetch (with ack_wait idle cycles), optional input wait, execute
   task automatic run_instr(input logic [15:0] instr, input int ack_wait,
                            input int in_wait, input logic [15:0] in_val);
      logic [7:0]  op;
      logic [16:0] res;
      logic        exp_ill;
      op = instr[15:8];
      for (int i = 0; i < ack_wait; i++) begin
         bus.imem_ack = 1'b0; bus.imem_rdata = 16'hDEAD;
         #1 chk_fetch();
         @(negedge clk);
      end
      bus.imem_ack = 1'b1; bus.imem_rdata = instr;
      #1 chk_fetch();
      @(negedge clk);
      bus.imem_ack = 1'b0; bus.imem_rdata = 16'h0;
      m_ir = instr;
      m_pc = m_pc + 8'd1;
      if (op == 8'hFC) begin
         for (int i = 0; i < in_wait; i++) begin
            bus.in_valid = 1'b0; bus.in_data = 16'hBEEF;
            #1;
            chk("wait_ready", 32'(bus.in_ready), 32'd1);
            chk("wait_req",   32'(bus.imem_req), 32'd0);
            chk("wait_pc",    32'(pc), 32'(m_pc));
            @(negedge clk);
         end
         bus.in_valid = 1'b1; bus.in_data = in_val;
         #1 chk("wait_ready_accept", 32'(bus.in_ready), 32'd1);
         @(negedge clk);
         bus.in_valid = 1'b0;
         m_inp = in_val;
      end
      exp_ill = !(op inside {8'h00, 8'h80, 8'h81, 8'hFF, [8'hF8:8'hFD]});
      #1;
      chk("exec_instr",   32'(bus.alu_instr), 32'(instr));
      chk("exec_inreg1",  32'(bus.alu_inreg1), 32'(m_r[instr[5:4]]));
      chk("exec_inreg2",  32'(bus.alu_inreg2), 32'(m_r[instr[3:2]]));
      chk("exec_inp",     32'(bus.alu_inp), 32'(m_inp));
      chk("exec_carryin", 32'(bus.alu_carryin), 32'(m_c));
      chk("exec_req",     32'(bus.imem_req), 32'd0);
      chk("exec_ready",   32'(bus.in_ready), 32'd0);
      chk("exec_illegal", 32'(illegal), 32'(exp_ill));
      chk("exec_pc",      32'(pc), 32'(m_pc));
      if (op >= 8'hF8 && op <= 8'hFD) begin
         res = alu_fn(instr, m_r[instr[5:4]], m_r[instr[3:2]], m_inp, m_c);
         m_r[instr[7:6]] = res[15:0];
         if (instr[1]) m_c = res[16];
      end else if (op == 8'h80) begin
         m_pc = instr[7:0];
      end else if (op == 8'h81 && m_c) begin
         m_pc = instr[7:0];
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      bus.imem_ack = 1'b1; bus.imem_rdata = 16'hFC40;
      bus.in_valid = 1'b1; bus.in_data = 16'h5555;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req",   32'(bus.imem_req), 32'd0);
      chk("rst_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      bus.imem_ack = 1'b0; bus.in_valid = 1'b0;
      #1;
      chk("reset_pc",      32'(pc), 32'h00);
      chk("reset_carry",   32'(carry_flag), 32'd0);
      chk("reset_halted",  32'(halted), 32'd0);
      chk("reset_illegal", 32'(illegal), 32'd0);
      chk("reset_req",     32'(bus.imem_req), 32'd1);
      chk("reset_addr",    32'(bus.imem_addr), 32'h00);
      chk("reset_ir",      32'(bus.alu_instr), 32'h0000);
      chk("reset_inp",     32'(bus.alu_inp), 32'h0000);

      // IN R1 with a 5-cycle input wait
      run_instr(16'hFC40, 0, 5, 16'h1234);
      chk("lit_r1_in", 32'(m_r[1]), 32'h1234);
      chk("lit_pc_after_in", 32'(pc), 32'h01);
      run_instr(16'hFC40, 0, 0, 16'hFFFF);   // R1 = FFFF
      run_instr(16'hFC80, 0, 1, 16'h0001);   // R2 = 0001
      run_instr(16'hF81A, 0, 0, 16'h0);      // R0 = R1+R2, cen
      chk("lit_add_carry", 32'(carry_flag), 32'd1);
      chk("lit_add_r0", 32'(m_r[0]), 32'h0000);
      run_instr(16'hF8EA, 0, 0, 16'h0);      // R3 = R2+R2, clears carry
      run_instr(16'hF818, 0, 0, 16'h0);      // R0 = R1+R2, no carry update
      chk("lit_nocen_carry", 32'(carry_flag), 32'd0);
      run_instr(16'h8142, 0, 0, 16'h0);      // JC not taken
      run_instr(16'hF81A, 0, 0, 16'h0);      // sets carry
      run_instr(16'h8142, 0, 0, 16'h0);      // JC taken
      chk("lit_jc_pc", 32'(pc), 32'h42);
      run_instr(16'hF81B, 0, 0, 16'h0);      // ADD with carry-in
      run_instr(16'hF9DA, 0, 0, 16'h0);      // SUB R3 = R1-R2
      run_instr(16'hFD3A, 0, 0, 16'h0);      // MUL R0 = R3*R2
      run_instr(16'hFAA0, 0, 0, 16'h0);      // INC R2
      run_instr(16'hFBA0, 0, 0, 16'h0);      // DEC R2
      run_instr(16'hF83C, 3, 0, 16'h0);      // delayed ack
      run_instr(16'h5512, 0, 0, 16'h0);      // undefined opcode
      run_instr(16'h0000, 2, 0, 16'h0);      // NOP
      run_instr(16'hF83C, 0, 0, 16'h0);
      run_instr(16'h80FF, 0, 0, 16'h0);      // JMP FF
      run_instr(16'h0000, 0, 0, 16'h0);      // NOP at FF -> wrap
      chk("lit_pc_wrap", 32'(pc), 32'h00);
      run_instr(16'hFF00, 0, 0, 16'h0);      // HALT
      bus.imem_ack = 1'b1; bus.imem_rdata = 16'hF81A;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("halt_halted", 32'(halted), 32'd1);
         chk("halt_req",    32'(bus.imem_req), 32'd0);
         chk("halt_pc",     32'(pc), 32'(m_pc));
         @(negedge clk);
      end
      bus.imem_ack = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      chk("lit_halt_rst_pc", 32'(pc), 32'h00);
      chk("lit_halt_rst_halted", 32'(halted), 32'd0);
      @(negedge clk);

      // reset while waiting for input with data offered
      run_instr(16'hFC40, 0, 0, 16'hA5A5);   // R1 = A5A5
      bus.imem_ack = 1'b1; bus.imem_rdata = 16'hFCC0;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      #1 chk("rstwait_ready", 32'(bus.in_ready), 32'd1);
      rst = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'h7777;
      @(negedge clk);
      rst = 1'b0; bus.in_valid = 1'b0;
      model_reset();
      run_instr(16'hF83C, 0, 0, 16'h0);      // reads R3, checks inp = 0
      chk("lit_rstwait_r3", 32'(m_r[3]), 32'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
